// File: rtl/divisor_arbiter.sv
// divisor_arbiter: round-robin front end that shares one signed divider
// among N_REQ requesters and sequences the divider Start/Done handshake.
// Optional divide-by-zero short-circuit: define DIVISOR_ARB_DIVZERO_CHECK_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no transaction; arbitrates once Div_Done has fallen
// S_RUN     | Div_Start high, operands frozen, waiting for Div_Done
// S_RELEASE | result returned, waiting for Div_Done to drop
// S_ZERO    | zero denominator captured; answer without the divider
//           | (present only with DIVISOR_ARB_DIVZERO_CHECK_EN)
module divisor_arbiter #(
  parameter int N_REQ = 2,
  parameter int W     = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   Req,
  input  logic [N_REQ*W-1:0] Num_in,
  input  logic [N_REQ*W-1:0] Den_in,
  output logic [N_REQ-1:0]   Gnt,
  output logic [N_REQ-1:0]   Rsp_valid,
  output logic [W-1:0]       Coc_out,
  output logic [W-1:0]       Res_out,
  output logic               Err,
  output logic               Busy,
  output logic               Div_Start,
  output logic [W-1:0]       Div_Num,
  output logic [W-1:0]       Div_Den,
  input  logic               Div_Done,
  input  logic [W-1:0]       Div_Coc,
  input  logic [W-1:0]       Div_Res
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

`ifdef DIVISOR_ARB_DIVZERO_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RELEASE, S_ZERO} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RELEASE} state_t;
`endif

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand;
  logic            win_found;
  logic            load;
  logic            rsp_load;
  logic [W-1:0]    num_a [N_REQ];
  logic [W-1:0]    den_a [N_REQ];

  // (base + step) mod N_REQ without a divider; base, step < N_REQ
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input logic [PW:0]   step);
    logic [PW:0] s;
    s = {1'b0, base} + step;
    if (s >= (PW+1)'(N_REQ)) s = s - (PW+1)'(N_REQ);
    return s[PW-1:0];
  endfunction

  // unpack the per-requester operand buses
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      num_a[i] = Num_in[i*W +: W];
      den_a[i] = Den_in[i*W +: W];
    end
  end

  // first pending request at or after ptr, searching upward with wrap
  always_comb begin
    win       = '0;
    cand      = '0;
    win_found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      cand = wrap_add(ptr_q, (PW+1)'(j));
      if (!win_found && Req[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state and datapath strobes
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    rsp_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        // a Done left over from the previous transaction must fall first
        if (win_found && !Div_Done) begin
          load = 1'b1;
`ifdef DIVISOR_ARB_DIVZERO_CHECK_EN
          state_d = (den_a[win] == '0) ? S_ZERO : S_RUN;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (Div_Done) begin
          rsp_load = 1'b1;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!Div_Done) state_d = S_IDLE;
      end
`ifdef DIVISOR_ARB_DIVZERO_CHECK_EN
      S_ZERO: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign Div_Start = (state_q == S_RUN);
  assign Busy      = (state_q != S_IDLE);

`ifdef DIVISOR_ARB_DIVZERO_CHECK_EN
  logic err_q;
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  // operand capture, ownership/pointer bookkeeping and response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      Gnt       <= '0;
      Rsp_valid <= '0;
      Coc_out   <= '0;
      Res_out   <= '0;
      Div_Num   <= '0;
      Div_Den   <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
`ifdef DIVISOR_ARB_DIVZERO_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      Gnt       <= '0;
      Rsp_valid <= '0;
      if (load) begin
        Gnt     <= ONE << win;
        Div_Num <= num_a[win];
        Div_Den <= den_a[win];
        owner_q <= win;
        ptr_q   <= wrap_add(win, (PW+1)'(1));
      end
      if (rsp_load) begin
        Rsp_valid <= ONE << owner_q;
        Coc_out   <= Div_Coc;
        Res_out   <= Div_Res;
`ifdef DIVISOR_ARB_DIVZERO_CHECK_EN
        err_q     <= 1'b0;
`endif
      end
`ifdef DIVISOR_ARB_DIVZERO_CHECK_EN
      if (state_q == S_ZERO) begin
        Rsp_valid <= ONE << owner_q;
        Coc_out   <= '1;
        Res_out   <= Div_Num;
        err_q     <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_divisor_arbiter.sv
// Bench for divisor_arbiter with a behavioural divider stub, a
// transaction-level reference model compared every cycle, and directed
// scenarios with literal expectations.
module tb_divisor_arbiter;

  localparam int N   = 2;
  localparam int LAT = 4;
`ifdef DIVISOR_ARB_DIVZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              RST;
  logic [N-1:0]      Req;
  logic signed [15:0] num [N];
  logic signed [15:0] den [N];
  logic [N*16-1:0]   Num_in, Den_in;
  logic [N-1:0]      Gnt, Rsp_valid;
  logic [15:0]       Coc_out, Res_out, Div_Num, Div_Den;
  logic              Err, Busy, Div_Start;
  logic              stub_done;
  logic [15:0]       stub_coc, stub_res;
  int                stub_cnt, stub_hold, hold_cfg;

  int total = 0;
  int bad   = 0;

  assign Num_in = {num[1], num[0]};
  assign Den_in = {den[1], den[0]};

  always #5 clk = ~clk;

  divisor_arbiter #(.N_REQ(N), .W(16)) dut (
    .CLK(clk), .RST(RST), .Req(Req), .Num_in(Num_in), .Den_in(Den_in),
    .Gnt(Gnt), .Rsp_valid(Rsp_valid), .Coc_out(Coc_out), .Res_out(Res_out),
    .Err(Err), .Busy(Busy), .Div_Start(Div_Start), .Div_Num(Div_Num),
    .Div_Den(Div_Den), .Div_Done(stub_done), .Div_Coc(stub_coc),
    .Div_Res(stub_res)
  );

  // divider semantics: truncation toward zero, remainder follows numerator
  function automatic logic [15:0] ref_q(logic signed [15:0] n, logic signed [15:0] d);
    if (d == 0) return 16'hFFFF;
    return 16'(n / d);
  endfunction
  function automatic logic [15:0] ref_r(logic signed [15:0] n, logic signed [15:0] d);
    if (d == 0) return n;
    return 16'(n % d);
  endfunction

  // divider stub: Done after LAT cycles of Start, held hold_cfg extra cycles
  always @(posedge clk) begin
    if (RST) begin
      stub_done <= 1'b0;
      stub_cnt  <= 0;
      stub_hold <= 0;
      stub_coc  <= '0;
      stub_res  <= '0;
    end else if (Div_Start && !stub_done) begin
      if (stub_cnt == LAT) begin
        stub_done <= 1'b1;
        stub_cnt  <= 0;
        stub_coc  <= ref_q(Div_Num, Div_Den);
        stub_res  <= ref_r(Div_Num, Div_Den);
        stub_hold <= hold_cfg;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end else if (!Div_Start && stub_done) begin
      if (stub_hold == 0) stub_done <= 1'b0;
      else                stub_hold <= stub_hold - 1;
    end
  end

  // reference model: one transaction at a time, rotating priority
  function automatic int pick(logic [N-1:0] r, int p);
    for (int j = 0; j < N; j++)
      if (r[(p + j) % N]) return (p + j) % N;
    return 0;
  endfunction

  int          m_ptr, m_owner, m_phase, m_win;
  bit          m_started = 1'b0;
  logic [N-1:0] e_gnt, e_rsp;
  logic [15:0] e_coc, e_res, e_num, e_den;
  logic        e_err;

  always_comb m_win = pick(Req, m_ptr);

  // model step: phase 0 free, 1 divider working, 2 Done draining, 3 zero answer
  always @(posedge clk) begin
    m_started <= 1'b1;
    if (RST) begin
      m_ptr <= 0; m_owner <= 0; m_phase <= 0;
      e_gnt <= '0; e_rsp <= '0; e_coc <= '0; e_res <= '0;
      e_num <= '0; e_den <= '0; e_err <= 1'b0;
    end else begin
      e_gnt <= '0;
      e_rsp <= '0;
      case (m_phase)
        0: if (Req != 0 && !stub_done) begin
             e_gnt   <= N'(1 << m_win);
             e_num   <= num[m_win];
             e_den   <= den[m_win];
             m_owner <= m_win;
             m_ptr   <= (m_win + 1) % N;
             m_phase <= (ZC && den[m_win] == 0) ? 3 : 1;
           end
        1: if (stub_done) begin
             e_rsp   <= N'(1 << m_owner);
             e_coc   <= ref_q(e_num, e_den);
             e_res   <= ref_r(e_num, e_den);
             e_err   <= 1'b0;
             m_phase <= 2;
           end
        2: if (!stub_done) m_phase <= 0;
        default: begin
             e_rsp   <= N'(1 << m_owner);
             e_coc   <= 16'hFFFF;
             e_res   <= e_num;
             e_err   <= 1'b1;
             m_phase <= 0;
           end
      endcase
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_started) begin
      chk("cmp_gnt",   32'(Gnt),       32'(e_gnt));
      chk("cmp_rsp",   32'(Rsp_valid), 32'(e_rsp));
      chk("cmp_busy",  32'(Busy),      32'(m_phase != 0));
      chk("cmp_start", 32'(Div_Start), 32'(m_phase == 1));
      chk("cmp_err",   32'(Err),       32'(e_err));
      chk16("cmp_coc", Coc_out, e_coc);
      chk16("cmp_res", Res_out, e_res);
      chk16("cmp_num", Div_Num, e_num);
      chk16("cmp_den", Div_Den, e_den);
    end
  end

  task automatic wait_gnt(string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (Gnt == 0 && n < 60);
    total++;
    if (Gnt == 0) begin bad++; $display("FAIL %s gnt timeout actual=0 required=grant", name); end
  endtask

  task automatic wait_rsp(string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (Rsp_valid == 0 && n < 60);
    total++;
    if (Rsp_valid == 0) begin bad++; $display("FAIL %s rsp timeout actual=0 required=valid", name); end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge clk);
    RST = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b1; Req = '0; hold_cfg = 0;
    num[0] = 0; den[0] = 1; num[1] = 0; den[1] = 1;
    repeat (3) @(negedge clk);
    chk("rst_gnt",   32'(Gnt), 0);
    chk("rst_busy",  32'(Busy), 0);
    chk("rst_start", 32'(Div_Start), 0);
    chk16("rst_coc", Coc_out, 16'h0000);
    RST = 1'b0;
    @(negedge clk);

    // single request 17/3
    num[0] = 17; den[0] = 3; Req = 2'b01;
    @(negedge clk);
    chk("t1_gnt",   32'(Gnt), 32'h1);
    chk("t1_start", 32'(Div_Start), 32'h1);
    Req = '0;
    wait_rsp("t1");
    chk("t1_rsp",   32'(Rsp_valid), 32'h1);
    chk16("t1_coc", Coc_out, 16'd5);
    chk16("t1_res", Res_out, 16'd2);
    chk("t1_err",   32'(Err), 0);
    repeat (3) @(negedge clk);
    chk("t1_idle",  32'(Busy), 0);

    // simultaneous requests, ptr = 0
    do_reset();
    num[0] = -23; den[0] = -5; num[1] = 17; den[1] = -3; Req = 2'b11;
    @(negedge clk);
    chk("t2_gnt0", 32'(Gnt), 32'h1);
    Req = 2'b10;
    wait_rsp("t2a");
    chk("t2_rsp0",   32'(Rsp_valid), 32'h1);
    chk16("t2_coc0", Coc_out, 16'd4);
    chk16("t2_res0", Res_out, -16'sd3);
    wait_gnt("t2b");
    chk("t2_gnt1", 32'(Gnt), 32'h2);
    Req = '0;
    wait_rsp("t2b");
    chk("t2_rsp1",   32'(Rsp_valid), 32'h2);
    chk16("t2_coc1", Coc_out, -16'sd5);
    chk16("t2_res1", Res_out, 16'd2);

    // both held high: strict rotation starting from 0 (ptr back at 0)
    num[0] = 15; den[0] = 3; num[1] = -18; den[1] = 3; Req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_gnt("t3");
      chk("t3_gnt", 32'(Gnt), (t % 2) ? 32'h2 : 32'h1);
      if (t == 3) Req = '0;
      wait_rsp("t3");
      chk16("t3_coc", Coc_out, (t % 2) ? -16'sd6 : 16'd5);
      chk16("t3_res", Res_out, 16'd0);
    end

    // reset in the middle of RUN
    num[0] = 100; den[0] = 7; Req = 2'b01;
    wait_gnt("t4a");
    Req = '0;
    repeat (2) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    chk("t4_start", 32'(Div_Start), 0);
    chk("t4_rsp",   32'(Rsp_valid), 0);
    RST = 1'b0;
    n = 0;
    repeat (10) begin @(negedge clk); if (Rsp_valid != 0) n++; end
    chk("t4_norsp", 32'(n), 0);
    num[0] = -20; den[0] = -5; Req = 2'b01;
    wait_gnt("t4b");
    chk("t4_gnt", 32'(Gnt), 32'h1);
    Req = '0;
    wait_rsp("t4b");
    chk16("t4_coc", Coc_out, 16'd4);
    chk16("t4_res", Res_out, 16'd0);

    // Done held after Start falls: next grant waits for it
    hold_cfg = 5;
    num[0] = 10; den[0] = 2; Req = 2'b01;
    wait_gnt("t5a");
    Req = '0;
    wait_rsp("t5a");
    chk16("t5_coc0", Coc_out, 16'd5);
    num[1] = 9; den[1] = 4; Req = 2'b10;
    n = 0;
    do begin @(negedge clk); n++; end while (Gnt == 0 && n < 40);
    chk("t5_gap",  32'(n), 32'd8);
    chk("t5_gnt1", 32'(Gnt), 32'h2);
    Req = '0;
    hold_cfg = 0;
    wait_rsp("t5b");
    chk16("t5_coc1", Coc_out, 16'd2);
    chk16("t5_res1", Res_out, 16'd1);
    repeat (12) @(negedge clk);

    // zero denominator
    num[0] = 17; den[0] = 0; Req = 2'b01;
    wait_gnt("t6");
    Req = '0;
`ifdef DIVISOR_ARB_DIVZERO_CHECK_EN
    chk("t6_nostart", 32'(Div_Start), 0);
    wait_rsp("t6");
    chk16("t6_coc", Coc_out, 16'hFFFF);
    chk16("t6_res", Res_out, 16'd17);
    chk("t6_err",   32'(Err), 32'h1);
`else
    chk("t6_start", 32'(Div_Start), 32'h1);
    wait_rsp("t6");
    chk16("t6_coc", Coc_out, 16'hFFFF);
    chk16("t6_res", Res_out, 16'd17);
    chk("t6_err",   32'(Err), 0);
`endif
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
